// File: rtl/efpga_cfg_wrapper_if.sv
// Bus bundle between the SoC configuration master / datapath and the eFPGA wrapper.
interface efpga_cfg_wrapper_if #(
  parameter int PW        = 32,
  parameter int CFG_WORDS = 64,
  parameter int DIN_W     = 96,
  parameter int DOUT_W    = 128
);
  localparam int CNT_W = $clog2(CFG_WORDS + 2);

  logic              cfg_start;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [PW-1:0]     cfg_data;
  logic              cfg_done;
  logic              cfg_err;
  logic [CNT_W-1:0]  cfg_cnt;
  logic              data_en;
  logic [DIN_W-1:0]  data_in;
  logic              data_valid_o;
  logic [DOUT_W-1:0] data_out;

  modport master (
    output cfg_start, cfg_valid, cfg_data, data_en, data_in,
    input  cfg_ready, cfg_done, cfg_err, cfg_cnt, data_valid_o, data_out
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, data_en, data_in,
    output cfg_ready, cfg_done, cfg_err, cfg_cnt, data_valid_o, data_out
  );
endinterface

// File: rtl/efpga_cfg_wrapper.sv
// eFPGA wrapper: handshaked bitstream loader with additive checksum and load timeout,
// plus a behavioural fabric model whose output is user data XORed with a config-derived key.
module fpga #(
  parameter int V         = 2,
  parameter int H         = 3,
  parameter int PW        = 32,
  parameter int SHW       = 7,
  parameter int CFG_WORDS = 64,
  parameter int DIN_W     = 96,
  parameter int DOUT_W    = 128
) (
  input  logic              clk,
  input  logic              nres,
  input  logic [PW-1:0]     prog_i,
  input  logic [SHW-1:0]    prog_shft,
  input  logic              data_en,
  input  logic [DIN_W-1:0]  data_in,
  output logic [DOUT_W-1:0] data_out
);
  logic [CFG_WORDS-1:0][PW-1:0] mem_r;
  logic [PW-1:0]                key_s;
  logic [DOUT_W-1:0]            key_rep_s;

  // configuration memory: prog_shft = k+1 writes word k
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      mem_r <= '0;
    end else begin
      for (int k = 0; k < CFG_WORDS; k++) begin
        if (prog_shft == SHW'(k + 1)) begin
          mem_r[k] <= prog_i;
        end
      end
    end
  end

  // key is the XOR of all configuration words
  always_comb begin
    key_s = '0;
    for (int k = 0; k < CFG_WORDS; k++) begin
      key_s = key_s ^ mem_r[k];
    end
  end

  for (genvar g = 0; g < DOUT_W; g++) begin : g_key
    assign key_rep_s[g] = key_s[(g + V * H) % PW];
  end

  assign data_out = (DOUT_W'(data_in) ^ key_rep_s) & {DOUT_W{data_en}};
endmodule

module efpga_cfg_wrapper #(
  parameter int V         = 2,
  parameter int H         = 3,
  parameter int PW        = 32,
  parameter int SHW       = 7,
  parameter int CFG_WORDS = 64,
  parameter int DIN_W     = 96,
  parameter int DOUT_W    = 128,
  parameter int TIMEOUT   = 1024
) (
  input logic               clk,
  input logic               nres,
  efpga_cfg_wrapper_if.slave bus
);
  localparam int CNT_W = $clog2(CFG_WORDS + 2);
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_CHECK, ST_RUN, ST_ERROR} state_t;

  state_t            state_r, state_s;
  logic [PW-1:0]     sum_r, prog_i_r;
  logic [SHW-1:0]    prog_shft_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [TW-1:0]     idle_r;
  logic              done_r, err_r, dvalid_r;
  logic [DOUT_W-1:0] dout_r, fab_out_s;
  logic              xfer_s, is_chk_s, timeout_s, enter_load_s, run_s, fab_en_s;

  assign xfer_s       = (state_r == ST_LOAD) && bus.cfg_valid;
  assign is_chk_s     = xfer_s && (cnt_r == CNT_W'(CFG_WORDS));
  // a transfer in the expiry cycle wins over the timeout
  assign timeout_s    = (state_r == ST_LOAD) && !bus.cfg_valid && (idle_r == TW'(TIMEOUT - 1));
  assign enter_load_s = (state_s == ST_LOAD) && (state_r != ST_LOAD);
  assign run_s        = (state_r == ST_RUN) && !bus.cfg_start;
  assign fab_en_s     = run_s && bus.data_en;

  // state register
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (bus.cfg_start) state_s = ST_LOAD;  else state_s = ST_IDLE;
      ST_LOAD:  if (is_chk_s)      state_s = ST_CHECK;
                else if (timeout_s) state_s = ST_ERROR;
                else               state_s = ST_LOAD;
      ST_CHECK: if (sum_r == '0)   state_s = ST_RUN;   else state_s = ST_ERROR;
      ST_RUN:   if (bus.cfg_start) state_s = ST_LOAD;  else state_s = ST_RUN;
      ST_ERROR: if (bus.cfg_start) state_s = ST_LOAD;  else state_s = ST_ERROR;
      default:  state_s = ST_IDLE;
    endcase
  end

  // loader bookkeeping: checksum, word count, idle timer and status flags
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      sum_r  <= '0;
      cnt_r  <= '0;
      idle_r <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (enter_load_s) begin
      sum_r  <= '0;
      cnt_r  <= '0;
      idle_r <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (xfer_s) begin
      sum_r  <= sum_r + bus.cfg_data;
      idle_r <= '0;
      if (cnt_r != CNT_W'(CFG_WORDS + 1)) cnt_r <= cnt_r + CNT_W'(1);
    end else if (state_r == ST_LOAD) begin
      idle_r <= idle_r + TW'(1);
      if (timeout_s) err_r <= 1'b1;
    end else if (state_r == ST_CHECK) begin
      done_r <= (sum_r == '0);
      err_r  <= (sum_r != '0);
    end
  end

  // fabric programming port; the checksum word is never forwarded
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      prog_i_r    <= '0;
      prog_shft_r <= '0;
    end else if (xfer_s && !is_chk_s) begin
      prog_i_r    <= bus.cfg_data;
      prog_shft_r <= SHW'(cnt_r) + SHW'(1);
    end else begin
      prog_shft_r <= '0;
    end
  end

  // registered user datapath, forced to zero outside RUN
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      dvalid_r <= 1'b0;
      dout_r   <= '0;
    end else begin
      dvalid_r <= fab_en_s;
      dout_r   <= run_s ? fab_out_s : '0;
    end
  end

  fpga #(
    .V(V), .H(H), .PW(PW), .SHW(SHW), .CFG_WORDS(CFG_WORDS), .DIN_W(DIN_W), .DOUT_W(DOUT_W)
  ) u_fabric (
    .clk       (clk),
    .nres      (nres),
    .prog_i    (prog_i_r),
    .prog_shft (prog_shft_r),
    .data_en   (fab_en_s),
    .data_in   (bus.data_in),
    .data_out  (fab_out_s)
  );

  assign bus.cfg_ready    = (state_r == ST_LOAD);
  assign bus.cfg_done     = done_r;
  assign bus.cfg_err      = err_r;
  assign bus.cfg_cnt      = cnt_r;
  assign bus.data_valid_o = dvalid_r;
  assign bus.data_out     = dout_r;
endmodule

// File: doc/efpga_cfg_wrapper.md
Name: efpga_cfg_wrapper

Overview:
- Parametrised successor to the fixed-size eFPGA top wrapper.
- Instantiates the `fpga` fabric with generic V/H.
- Adds a handshaked bitstream loader that drives the fabric programming port (prog_i/prog_shft), checks an additive checksum and times out stalled loads.
- Gates user data into the fabric only once configuration has been verified.
- Sits between the SoC configuration master / datapath and the fabric.

Parameters:
- V, 2, fabric tile rows, passed to `fpga`.
- H, 3, fabric tile columns, passed to `fpga`.
- PW, 32, programming word width (fabric prog_i width).
- SHW, 7, fabric prog_shft width; requires 2^SHW > CFG_WORDS.
- CFG_WORDS, 64, number of payload words per bitstream (excludes checksum word).
- DIN_W, 96, user data input width.
- DOUT_W, 128, user data output width.
- TIMEOUT, 1024, maximum idle cycles between accepted words in LOAD.

Ports:
- clk  in  1  system clock.
- nres  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle pulse: begin (re)configuration.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  loader accepts a word this cycle.
- cfg_data  in  PW  bitstream / checksum word.
- cfg_done  out  1  configuration verified, fabric running.
- cfg_err  out  1  checksum mismatch or timeout.
- cfg_cnt  out  $clog2(CFG_WORDS+2)  words accepted in current load, including the checksum word.
- data_en  in  1  user data valid (honoured only in RUN).
- data_in  in  DIN_W  user data to fabric.
- data_valid_o  out  1  registered data_en of the RUN cycle.
- data_out  out  DOUT_W  registered fabric output.

Behaviour:
- Clock and reset: one clock, clk; reset nres is asynchronous, active-low.
- Reset values: state=IDLE; cfg_ready, cfg_done, cfg_err, data_valid_o = 0; cfg_cnt = 0; data_out = 0; fabric prog_i = 0, prog_shft = 0, data_en = 0. Reset mid-LOAD discards the partial load; the fabric must be re-programmed.
- States: IDLE, LOAD, CHECK, RUN, ERROR.
- IDLE:
  - cfg_start -> LOAD next cycle.
  - On that transition: sum = 0, cfg_cnt = 0, idle timer = 0, cfg_done = 0, cfg_err = 0.
- LOAD:
  - cfg_ready = 1 (combinational from state).
  - Transfer occurs on cfg_valid & cfg_ready.
  - Payload word k (k = 0..CFG_WORDS-1): next cycle fabric prog_i = word and prog_shft = k+1 for exactly one cycle; otherwise prog_shft = 0 and prog_i holds its last value.
  - Every accepted word: sum <= sum + word (mod 2^PW); cfg_cnt increments.
  - Word index CFG_WORDS is the checksum word: added to sum, not forwarded (prog_shft stays 0), then -> CHECK.
  - Timeout: idle timer counts cycles without a transfer and clears on a transfer. When it reaches TIMEOUT -> ERROR, cfg_err = 1.
  - cfg_start in LOAD is ignored.
- CHECK (one cycle, cfg_ready = 0):
  - sum == 0 -> RUN, cfg_done = 1.
  - Otherwise -> ERROR, cfg_err = 1.
- RUN:
  - Fabric data_en = data_en; data_in is passed straight to the fabric.
  - data_out <= fabric data_out and data_valid_o <= data_en, giving 1-cycle latency.
  - cfg_start -> LOAD: clears cfg_done, forces fabric data_en = 0 from that cycle, data_out <= 0, data_valid_o <= 0.
- ERROR:
  - cfg_err stays 1; fabric data gated; data_out = 0.
  - cfg_start -> LOAD, clearing cfg_err.
- Outside RUN: fabric data_en = 0, data_valid_o = 0, data_out held at 0.
- Simultaneous events:
  - cfg_start and cfg_valid in the same IDLE cycle: only the start is taken (cfg_ready was 0).
  - Timeout expiry and a transfer in the same cycle: the transfer wins.
- cfg_cnt saturates at CFG_WORDS+1 and holds its value after CHECK until the next cfg_start.

Test Plan:
- Valid load, CFG_WORDS=4: words 1, 2, 3, 4 then checksum 0xFFFFFFF6, cfg_valid held high -> prog_shft = 1, 2, 3, 4 on consecutive cycles with matching prog_i; checksum not forwarded; cfg_done = 1 two cycles after the checksum transfer; cfg_cnt = 5.
- Bad checksum: words 1, 2, 3, 4 then 0x00000000 -> cfg_err = 1, cfg_done = 0; data_en = 1 in ERROR gives data_valid_o = 0, data_out = 0.
- Backpressure gaps: cfg_valid toggled 1-0-0-1 with idle gaps shorter than TIMEOUT -> only transferred words are forwarded; the prog_shft sequence stays contiguous 1..4 without duplicates; load passes.
- Timeout with TIMEOUT=8: two words sent, then cfg_valid = 0 for 8 cycles -> ERROR with cfg_err = 1. A following cfg_start and a full valid load recovers to cfg_done = 1.
- RUN datapath: after a good load, data_en = 1 with data_in = 0x…A5 -> data_valid_o = 1 exactly one cycle later and data_out equals the fabric output registered. cfg_start in RUN -> data_valid_o = 0 and data_out = 0 from the next cycle.
- Async reset mid-LOAD: assert nres = 0 between clock edges after 2 words -> all outputs read 0 immediately; after release, state is IDLE with cfg_ready = 0.
